// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants and controller state type
package sha256_pkg;

  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_MSG_WORDS = 16;

  typedef enum logic [2:0] {
    CTRL_IDLE   = 3'd0,
    CTRL_INIT   = 3'd1,
    CTRL_ROUND  = 3'd2,
    CTRL_UPDATE = 3'd3,
    CTRL_DONE   = 3'd4
  } ctrl_state_t;

  // Initial hash value H0..H7, consumed by the datapath when o_init_h is high.
  localparam logic [31:0] SHA256_IV_0 = 32'h6a09e667;
  localparam logic [31:0] SHA256_IV_1 = 32'hbb67ae85;
  localparam logic [31:0] SHA256_IV_2 = 32'h3c6ef372;
  localparam logic [31:0] SHA256_IV_3 = 32'ha54ff53a;
  localparam logic [31:0] SHA256_IV_4 = 32'h510e527f;
  localparam logic [31:0] SHA256_IV_5 = 32'h9b05688c;
  localparam logic [31:0] SHA256_IV_6 = 32'h1f83d9ab;
  localparam logic [31:0] SHA256_IV_7 = 32'h5be0cd19;

  localparam logic [7:0][31:0] SHA256_IV = {
    SHA256_IV_7, SHA256_IV_6, SHA256_IV_5, SHA256_IV_4,
    SHA256_IV_3, SHA256_IV_2, SHA256_IV_1, SHA256_IV_0
  };

endpackage

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - control FSM sequencing one SHA-256 block compression
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS    = SHA256_ROUNDS,
  parameter int MSG_WORDS = SHA256_MSG_WORDS,
  parameter int J_W       = 7
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_first,
  input  logic [J_W-1:0] j,
  output logic           clr_j,
  output logic           cnt_j_en,
  output logic           o_ld_msg,
  output logic           o_init_h,
  output logic           o_ld_wv,
  output logic           o_round_en,
  output logic           o_w_sel_msg,
  output logic           o_upd_h,
  output logic           o_ready,
  output logic           o_busy,
  output logic           o_done
);

  localparam logic [J_W-1:0] LAST_J = J_W'(ROUNDS - 1);
  localparam logic [J_W-1:0] MSG_J  = J_W'(MSG_WORDS);

  ctrl_state_t state_q, state_d;
  logic        first_q, first_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CTRL_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    clr_j       = 1'b0;
    cnt_j_en    = 1'b0;
    o_ld_msg    = 1'b0;
    o_init_h    = 1'b0;
    o_ld_wv     = 1'b0;
    o_round_en  = 1'b0;
    o_w_sel_msg = 1'b0;
    o_upd_h     = 1'b0;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;

    unique case (state_q)
      CTRL_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          first_d = i_first;
          state_d = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        clr_j    = 1'b1;
        o_ld_msg = 1'b1;
        o_ld_wv  = 1'b1;
        o_init_h = first_q;
        o_busy   = 1'b1;
        state_d  = CTRL_ROUND;
      end
      CTRL_ROUND: begin
        o_round_en  = 1'b1;
        cnt_j_en    = 1'b1;
        o_busy      = 1'b1;
        o_w_sel_msg = (j < MSG_J);
        // >= rather than == so a corrupted counter still terminates the block
        if (j >= LAST_J) begin
          state_d = CTRL_UPDATE;
        end
      end
      CTRL_UPDATE: begin
        o_upd_h = 1'b1;
        clr_j   = 1'b1;
        o_busy  = 1'b1;
        state_d = CTRL_DONE;
      end
      CTRL_DONE: begin
        o_done  = 1'b1;
        o_busy  = 1'b1;
        state_d = CTRL_IDLE;
      end
      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Control FSM for one SHA-256 compression of a 512-bit block. It accepts a start request and sequences message load, working-variable init and 64 rounds, then issues the hash update and a done pulse. It drives the round counter `sha256_counter_j` through `clr_j`/`cnt_j_en` and consumes its `j` output. It owns no datapath; every output is a datapath strobe or a handshake flag.

## Interface

Parameters:
- `ROUNDS`, 64: compression rounds per block.
- `MSG_WORDS`, 16: rounds that take W directly from the message words.
- `J_W`, 7: width of `j`. Must satisfy 2^J_W > ROUNDS.

Ports:
- `i_clk`  in  1  rising-edge clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_first`  in  1  block is the first of a message (H is loaded from the IV); sampled with `i_start`.
- `j`  in  J_W  current round index from the round counter.
- `clr_j`  out  1  clear the round counter.
- `cnt_j_en`  out  1  increment the round counter.
- `o_ld_msg`  out  1  load 16 message words into the schedule registers.
- `o_init_h`  out  1  load H0..H7 from the IV.
- `o_ld_wv`  out  1  load a..h from H (the IV when `o_init_h` is high).
- `o_round_en`  out  1  perform one compression round.
- `o_w_sel_msg`  out  1  W(j) comes from a message word (j < MSG_WORDS), else from the schedule.
- `o_upd_h`  out  1  H(i) += working variable(i).
- `o_ready`  out  1  idle; a start is accepted this cycle.
- `o_busy`  out  1  block in progress.
- `o_done`  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, INIT, ROUND, UPDATE, DONE. All outputs are Moore, decoded from state, except `o_w_sel_msg`, which also depends on `j`.
- IDLE
  - Outputs: `o_ready`=1, all others 0.
  - `i_start`=1: latch `i_first` into `first_q` and go to INIT.
- INIT (1 cycle)
  - Outputs: `clr_j`=1, `o_ld_msg`=1, `o_ld_wv`=1, `o_init_h`=`first_q`, `o_busy`=1.
  - Next state: ROUND.
- ROUND
  - Outputs: `o_round_en`=1, `cnt_j_en`=1, `o_busy`=1, `o_w_sel_msg`=(j < MSG_WORDS).
  - j ≥ ROUNDS-1: go to UPDATE. The ≥ comparison is a guard against a corrupted counter.
- UPDATE (1 cycle)
  - Outputs: `o_upd_h`=1, `clr_j`=1, `o_busy`=1.
  - Next state: DONE.
- DONE (1 cycle)
  - Outputs: `o_done`=1, `o_busy`=1.
  - Next state: IDLE.
- `i_start` outside IDLE is ignored and not queued.
- `i_first` outside the accept cycle is ignored.
- `o_ready` and `o_busy` are mutually exclusive and always complementary.
- `clr_j` and `cnt_j_en` are never asserted in the same cycle.
- The counter is cleared in INIT and again in UPDATE, so `j`=0 whenever the block is idle.

## Timing

- Reset
  - `i_rst`=1 at an edge forces IDLE and `first_q`=0, from any state including mid-round.
  - Next-cycle outputs: `o_ready`=1, all others 0.
  - No partial `o_upd_h` or `o_done` is emitted after a reset.
  - Reset does not clear the external counter. The controller's next INIT clears it.
- Start accepted at edge T (IDLE, `i_start`=1):
  - INIT in cycle T+1.
  - ROUND in cycles T+2..T+65, with j = 0..63.
  - UPDATE in T+66, DONE in T+67.
  - `o_ready`=1 again in T+68.
- Latency: 67 cycles from accept to the `o_done` pulse. Issue interval: 68 cycles.
- Counter interaction
  - j increments on every ROUND edge. j reads 64 in the UPDATE cycle, then 0 after the UPDATE edge.
  - `o_w_sel_msg`=1 for exactly the first 16 ROUND cycles.
- Back-to-back: `i_start` held high in the cycle `o_ready` returns is accepted immediately.

## Structure

- Shared package `sha256_pkg` holds:
  - the state enum `ctrl_state_t`;
  - constants `SHA256_ROUNDS`=64 and `SHA256_MSG_WORDS`=16;
  - the IV constants, used by the datapath.
- One sequential process for the state register and `first_q`; one combinational decode for next state and outputs.
- No sub-module: the round counter `sha256_counter_j` is instantiated beside the controller in the core top, not inside it.

## Test plan

- Single block, `i_first`=1, start at T: `o_init_h`=1 only at T+1; `o_round_en` high for exactly 64 cycles; `o_w_sel_msg` high for 16; `o_upd_h` at T+66; `o_done` at T+67.
- Two back-to-back blocks (`i_first`=1, then 0), `i_start` held high: second accept occurs at T+68; `o_init_h`=0 for the second block; exactly two `o_done` pulses, 68 cycles apart.
- `i_start` pulsed at T+10 and T+40 during a block: no effect; the sequence and cycle counts are unchanged.
- `i_rst` asserted at round j=30: next cycle is IDLE, `o_ready`=1, no `o_upd_h`/`o_done`; a following start runs a full 64 rounds from j=0.
- Counter forced to j=70 during ROUND: transition to UPDATE in the next cycle, followed by a clean `o_done`.
- Assertions on every cycle:
  - never `clr_j` and `cnt_j_en` together;
  - `o_ready` XOR `o_busy` = 1;
  - `o_done` width is exactly 1.
